mem_port_arbiter: RTL

- Shares the single-port unified memory between instruction fetch (IF, port 0) and load/store unit (LSU, port 1) of the pipelined RV32I core.
- Arbitrates requests and holds one outstanding transaction at a time.
- Drives the address/write-data select of the memory-side 2:1 32-bit muxes and routes read data back to the owner.
- LSU has priority; an anti-starvation counter guarantees IF progress.

---
 rtl/mem_port_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter for the unified memory: IF (port 0) and LSU (port 1) share one
// outstanding transaction; LSU has priority, bounded by an IF anti-starvation counter.
module mem_port_arbiter #(
  parameter int MAX_WAIT = 3,
  parameter int TIMEOUT  = 64
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_if_req,
  input  logic [31:0] i_if_addr,
  output logic        o_if_gnt,
  output logic        o_if_rvalid,
  output logic [31:0] o_if_rdata,
  input  logic        i_lsu_req,
  input  logic        i_lsu_we,
  input  logic [31:0] i_lsu_addr,
  input  logic [31:0] i_lsu_wdata,
  input  logic [3:0]  i_lsu_bmask,
  output logic        o_lsu_gnt,
  output logic        o_lsu_rvalid,
  output logic [31:0] o_lsu_rdata,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_bmask,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata,
  output logic        o_sel,
  output logic        o_err,
  output logic [1:0]  o_state
);

  // Handshakes: requesters hold *_req until *_gnt (a combinational accept in IDLE);
  // o_mem_req is held with stable fields until i_mem_ack; *_rvalid is a one-cycle strobe.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEM  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] STARVE_MAX = 4'(MAX_WAIT);
  localparam logic [9:0] TO_LAST    = 10'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [3:0]  starve_cnt;
  logic [9:0]  to_cnt;
  logic        if_wins;
  logic        mem_done;
  logic        timeout_hit;
  logic [31:0] cap_data;

  assign o_state     = state;
  assign mem_done    = (state == MEM) && (i_mem_ack || (to_cnt == TO_LAST));
  // Ack on the final cycle takes precedence over the timeout.
  assign timeout_hit = mem_done && !i_mem_ack;
  assign cap_data    = (i_mem_ack && !o_mem_we) ? i_mem_rdata : 32'h0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_if_req || i_lsu_req) state_nxt = MEM;
      MEM:     if (mem_done) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    if_wins   = i_if_req && (!i_lsu_req || (starve_cnt == STARVE_MAX));
    o_if_gnt  = 1'b0;
    o_lsu_gnt = 1'b0;
    if (state == IDLE) begin
      o_if_gnt  = if_wins;
      o_lsu_gnt = i_lsu_req && !if_wins;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_sel        <= 1'b0;
      o_mem_req    <= 1'b0;
      o_mem_we     <= 1'b0;
      o_mem_addr   <= 32'h0;
      o_mem_wdata  <= 32'h0;
      o_mem_bmask  <= 4'h0;
      o_if_rvalid  <= 1'b0;
      o_if_rdata   <= 32'h0;
      o_lsu_rvalid <= 1'b0;
      o_lsu_rdata  <= 32'h0;
      o_err        <= 1'b0;
      starve_cnt   <= 4'h0;
      to_cnt       <= 10'h0;
    end else begin
      o_if_rvalid  <= 1'b0;
      o_lsu_rvalid <= 1'b0;
      o_err        <= 1'b0;
      if (o_if_gnt) begin
        o_sel       <= 1'b0;
        o_mem_req   <= 1'b1;
        o_mem_we    <= 1'b0;
        o_mem_addr  <= i_if_addr;
        o_mem_wdata <= 32'h0;
        o_mem_bmask <= 4'h0;
        starve_cnt  <= 4'h0;
      end else if (o_lsu_gnt) begin
        o_sel       <= 1'b1;
        o_mem_req   <= 1'b1;
        o_mem_we    <= i_lsu_we;
        o_mem_addr  <= i_lsu_addr;
        o_mem_wdata <= i_lsu_wdata;
        o_mem_bmask <= i_lsu_we ? i_lsu_bmask : 4'h0;
        if (i_if_req && (starve_cnt != STARVE_MAX)) starve_cnt <= starve_cnt + 4'h1;
      end
      if (state == MEM) begin
        if (mem_done) begin
          o_mem_req <= 1'b0;
          to_cnt    <= 10'h0;
          o_err     <= timeout_hit;
          // Only the owner's data register moves; the other port keeps its last value.
          if (o_sel) begin
            o_lsu_rvalid <= 1'b1;
            o_lsu_rdata  <= cap_data;
          end else begin
            o_if_rvalid <= 1'b1;
            o_if_rdata  <= cap_data;
          end
        end else begin
          to_cnt <= to_cnt + 10'h1;
        end
      end
    end
  end

endmodule
